shift_add_multiplier: RTL and testbench
=======================================

Name: shift_add_multiplier

Overview:
- Multi-cycle unsigned shift-and-add multiplier that executes the MUL opcode for the mini ALU.
- Replaces the combinational adder chain with a sequential unit.
- The decode stage issues the operands and destination address with a start pulse.
- The block returns a full-width product and the write address one cycle-accurate latency later. The ALU drives the RAM write from these outputs.

Parameters:
- WIDTH, 8, operand width in bits; the product is 2*WIDTH bits (16 at default, matching the RAM data width).
- ADDR_W, 8, width of the destination-address tag carried alongside the operation.

Ports:
- Clock  input  1  system clock, all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- iStart  input  1  one-cycle request to begin a multiply.
- iOperandA  input  WIDTH  multiplicand (wSourceData1 low bits).
- iOperandB  input  WIDTH  multiplier (wSourceData0 low bits).
- iDestination  input  ADDR_W  RAM write address for the result.
- oBusy  output  1  high while an operation is in progress (RUN state); the IP must stall while high.
- oDone  output  1  one-cycle pulse: oResult/oWriteAddr valid, write-enable qualifier.
- oResult  output  2*WIDTH  product, held until next accepted start.
- oWriteAddr  output  ADDR_W  latched iDestination, held with oResult.

Behaviour:
- Clocking and reset:
  - One clock (Clock); reset is synchronous and active-high (Reset). The reset polarity and synchronicity are fixed.
  - Reset, when high at a posedge, overrides every other input, including an iStart in the same cycle.
  - Reset values: state=IDLE, oBusy=0, oDone=0, oResult=0, oWriteAddr=0, internal accumulator/shift registers/counter=0.
- States: IDLE, RUN, DONE (registered, encoded 2 bits).
- IDLE:
  - iStart=1 at an edge → load A_reg={WIDTH'0,iOperandA}, B_reg=iOperandB, P=0, count=0, latch iDestination → RUN.
  - iStart=0 → stay.
- RUN, each edge (one iteration):
  - if B_reg[0], P <= P + A_reg (2*WIDTH-bit add, carry-out discarded; cannot overflow for unsigned operands);
  - A_reg <= A_reg<<1; B_reg <= B_reg>>1; count <= count+1.
  - When count==WIDTH-1 at an edge, that iteration completes, oResult <= final P, and state → DONE.
- DONE:
  - oDone=1 for exactly one cycle.
  - iStart=1 in this cycle is accepted (back-to-back): operands are loaded and state → RUN.
  - Otherwise → IDLE.
- Latency: WIDTH iterations always, no early termination on zero operands (deterministic timing for stall logic).
  - oDone is high in the cycle after the edge that is WIDTH edges after the start-sampling edge.
  - WIDTH=8: start sampled at edge 0, oDone high between edges 8 and 9.
- oBusy = (state==RUN), combinational from the state register.
- iStart while in RUN: ignored, no effect on operands, tag, or count.
- Operand/tag inputs are don't-care except at an accepted start edge.
- oResult and oWriteAddr:
  - change only at the completion edge (or reset);
  - hold their values through IDLE and through a following RUN until the next completion.
- Reset mid-RUN: abort; no oDone pulse is produced; outputs are cleared per the reset values.
- Arithmetic:
  - fully unsigned; oResult == iOperandA*iOperandB exactly, mod 2^(2*WIDTH) (never truncated);
  - count is ceil(log2(WIDTH))+1 bits wide, so WIDTH a power of two does not wrap early.

Decomposition:
- Shared definitions file: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; the MUL opcode constant stays with the existing opcode defines.
- Natural sub-module: mul_iteration_counter, a small synchronous-reset up-counter with load/enable and a terminal-count output (count==WIDTH-1).
- The datapath (P, A_reg, B_reg) and the FSM stay in the top module.

Test Plan:
- Reset asserted 3 cycles, then released → oBusy=0, oDone=0, oResult=16'h0000, oWriteAddr=8'h00.
- iStart, A=5, B=3, Dest=8'h07 → oBusy high 8 cycles; oDone pulses exactly 8 edges after start with oResult=16'h000F, oWriteAddr=8'h07; oResult still 16'h000F 5 cycles later.
- A=8'hFF, B=8'hFF → oResult=16'hFE01. Then A=0, B=8'hC8 → oResult=16'h0000 with the same 8-cycle latency.
- A=12, B=10; pulse iStart again at cycle 3 with A=1, B=1 → ignored; oResult=16'h0078 (120).
- Start A=7, B=9; assert Reset at cycle 4 → no oDone ever, state IDLE, oResult=0. A new start A=2, B=3 then yields 16'h0006.
- A=6, B=7, Dest=8'h01; iStart held high in the DONE cycle with A=4, B=4, Dest=8'h02 → first oDone shows 16'h002A/8'h01; second oDone exactly 8 edges later shows 16'h0010/8'h02; oBusy low only during the DONE cycle.

Source files
------------

// File: rtl/shift_add_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding, default sizes and the iteration-counter width helper.
package shift_add_multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_ADDR_W = 8;

  // One extra bit so a power-of-two WIDTH never wraps before the last iteration.
  function automatic int count_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Decode-stage <-> multiplier bus: start request with operands/tag in,
// busy/done status and full-width product with write address out.
//
// Handshake: iStart is a single-cycle request, accepted only when the
// multiplier is IDLE or in its DONE cycle (oBusy=0); while oBusy=1 the issuer
// must stall and any iStart is ignored. oDone is a one-cycle valid qualifier
// for oResult/oWriteAddr; there is no back-pressure on the result side.
interface shift_add_multiplier_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
);

  logic                 iStart;
  logic [WIDTH-1:0]     iOperandA;
  logic [WIDTH-1:0]     iOperandB;
  logic [ADDR_W-1:0]    iDestination;
  logic                 oBusy;
  logic                 oDone;
  logic [2*WIDTH-1:0]   oResult;
  logic [ADDR_W-1:0]    oWriteAddr;

  modport master (
    output iStart,
    output iOperandA,
    output iOperandB,
    output iDestination,
    input  oBusy,
    input  oDone,
    input  oResult,
    input  oWriteAddr
  );

  modport slave (
    input  iStart,
    input  iOperandA,
    input  iOperandB,
    input  iDestination,
    output oBusy,
    output oDone,
    output oResult,
    output oWriteAddr
  );

endinterface

// File: rtl/shift_add_multiplier_counter.sv
// Iteration counter for the multiplier: synchronous-reset up-counter with
// clear-load and enable, flagging the last iteration (count == LAST).
module mul_iteration_counter #(
  parameter int LAST  = 7,
  parameter int CNT_W = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Load restarts the iteration sequence at zero; it wins over enable.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == CNT_W'(LAST));

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier for the ALU MUL opcode:
// fixed WIDTH-iteration latency, full 2*WIDTH product plus write-address tag.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                    Clock,
  input  logic                    Reset,
  shift_add_multiplier_if.slave   bus,
  output state_t                  state_o
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = count_width(WIDTH);

  state_t state_q, state_d;

  logic [PW-1:0]     a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [PW-1:0]     p_q, p_d;
  logic [ADDR_W-1:0] tag_q, tag_d;
  logic [PW-1:0]     result_q, result_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;

  logic          load;
  logic          step;
  logic          complete;
  logic          last_iter;
  logic [PW-1:0] p_sum;

  mul_iteration_counter #(
    .LAST  (WIDTH - 1),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk_i  (Clock),
    .rst_i  (Reset),
    .load_i (load),
    .en_i   (step),
    .tc_o   (last_iter)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    step     = 1'b0;
    complete = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.iStart) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last_iter) begin
          complete = 1'b1;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        // A start in the done cycle is taken immediately so issue never bubbles.
        if (bus.iStart) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Carry-out cannot occur for unsigned operands, so the sum stays PW bits.
  assign p_sum = b_q[0] ? (p_q + a_q) : p_q;

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    p_d      = p_q;
    tag_d    = tag_q;
    result_d = result_q;
    waddr_d  = waddr_q;
    if (load) begin
      a_d   = {{WIDTH{1'b0}}, bus.iOperandA};
      b_d   = bus.iOperandB;
      p_d   = '0;
      tag_d = bus.iDestination;
    end else if (step) begin
      p_d = p_sum;
      a_d = a_q << 1;
      b_d = b_q >> 1;
      // Visible outputs move only on completion so they stay stable across a new run.
      if (complete) begin
        result_d = p_sum;
        waddr_d  = tag_q;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_q      <= '0;
      b_q      <= '0;
      p_q      <= '0;
      tag_q    <= '0;
      result_q <= '0;
      waddr_q  <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      p_q      <= p_d;
      tag_q    <= tag_d;
      result_q <= result_d;
      waddr_q  <= waddr_d;
    end
  end

  assign bus.oBusy      = (state_q == ST_RUN);
  assign bus.oDone      = (state_q == ST_DONE);
  assign bus.oResult    = result_q;
  assign bus.oWriteAddr = waddr_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: vector table, hand-written
// multi-cycle corner cases and randomized products against a plain a*b model.
module tb_shift_add_multiplier;
  import shift_add_multiplier_pkg::*;

  localparam int WIDTH   = 8;
  localparam int ADDR_W  = 8;
  localparam int LATENCY = WIDTH;
  localparam int TIMEOUT = 40;

  logic   clk;
  logic   rst;
  state_t dbg_state;

  int checks;
  int errors;

  logic [ADDR_W+2*WIDTH-1:0] exp_q[$];

  shift_add_multiplier_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  shift_add_multiplier #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .Clock   (clk),
    .Reset   (rst),
    .bus     (bus),
    .state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // driver: one-cycle start; returns at the negedge after the sampling edge
  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [ADDR_W-1:0] dest);
    @(negedge clk);
    bus.iStart       = 1'b1;
    bus.iOperandA    = a;
    bus.iOperandB    = b;
    bus.iDestination = dest;
    @(negedge clk);
    bus.iStart       = 1'b0;
    bus.iOperandA    = WIDTH'($urandom);
    bus.iOperandB    = WIDTH'($urandom);
    bus.iDestination = ADDR_W'($urandom);
  endtask

  // Counts negedges until oDone; also records whether oBusy stayed high meanwhile.
  task automatic wait_done(output int lat, output bit busy_ok);
    lat     = 0;
    busy_ok = 1'b1;
    while (lat < TIMEOUT) begin
      if (bus.oBusy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
      if (bus.oDone === 1'b1) break;
    end
  endtask

  function automatic logic [2*WIDTH-1:0] model_mul(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
    int unsigned prod;
    prod = int'(a) * int'(b);
    return (2*WIDTH)'(prod);
  endfunction

  // scoreboard pop + compare at an oDone negedge
  task automatic score(input string name);
    logic [ADDR_W+2*WIDTH-1:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({name, "_result"}, 32'(bus.oResult), 32'(e[2*WIDTH-1:0]));
      check({name, "_waddr"}, 32'(bus.oWriteAddr), 32'(e[ADDR_W+2*WIDTH-1:2*WIDTH]));
    end
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [ADDR_W-1:0] dest,
                        input logic [2*WIDTH-1:0] exp_p);
    int lat;
    bit busy_ok;
    exp_q.push_back({dest, exp_p});
    start_op(a, b, dest);
    wait_done(lat, busy_ok);
    check({name, "_latency"}, 32'(lat), 32'(LATENCY));
    check({name, "_busy_run"}, 32'(busy_ok), 32'd1);
    check({name, "_busy_done"}, 32'(bus.oBusy), 32'd0);
    score(name);
    @(negedge clk);
    check({name, "_done_pulse"}, 32'(bus.oDone), 32'd0);
  endtask

  typedef struct {
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [ADDR_W-1:0]  dest;
    logic [2*WIDTH-1:0] exp_p;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat;
    int total;
    bit busy_ok;
    bit saw_done;
    logic [WIDTH-1:0] ra, rb;
    logic [ADDR_W-1:0] rd;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.iStart       = 1'b0;
    bus.iOperandA    = '0;
    bus.iOperandB    = '0;
    bus.iDestination = '0;

    vecs[0] = '{a: 8'd5,   b: 8'd3,   dest: 8'h07, exp_p: 16'h000F};
    vecs[1] = '{a: 8'hFF,  b: 8'hFF,  dest: 8'h10, exp_p: 16'hFE01};
    vecs[2] = '{a: 8'h00,  b: 8'hC8,  dest: 8'h11, exp_p: 16'h0000};
    vecs[3] = '{a: 8'hC8,  b: 8'h00,  dest: 8'hFF, exp_p: 16'h0000};
    vecs[4] = '{a: 8'h80,  b: 8'h80,  dest: 8'h3C, exp_p: 16'h4000};
    vecs[5] = '{a: 8'h01,  b: 8'hFF,  dest: 8'hA5, exp_p: 16'h00FF};

    // reset state
    do_reset(3);
    check("rst_busy", 32'(bus.oBusy), 32'd0);
    check("rst_done", 32'(bus.oDone), 32'd0);
    check("rst_result", 32'(bus.oResult), 32'h0000);
    check("rst_waddr", 32'(bus.oWriteAddr), 32'h00);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // table vectors
    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].dest, vecs[i].exp_p);
    end

    // result holds through idle
    run_op("hold", 8'd5, 8'd3, 8'h07, 16'h000F);
    repeat (5) @(negedge clk);
    check("hold_result", 32'(bus.oResult), 32'h000F);
    check("hold_waddr", 32'(bus.oWriteAddr), 32'h07);

    // start while running is ignored
    exp_q.push_back({8'h20, 16'h0078});
    start_op(8'd12, 8'd10, 8'h20);
    repeat (2) @(negedge clk);
    bus.iStart       = 1'b1;
    bus.iOperandA    = 8'd1;
    bus.iOperandB    = 8'd1;
    bus.iDestination = 8'h55;
    @(negedge clk);
    bus.iStart = 1'b0;
    check("ign_busy_mid", 32'(bus.oBusy), 32'd1);
    check("ign_result_held", 32'(bus.oResult), 32'h000F);
    wait_done(lat, busy_ok);
    total = lat + 3;
    check("ign_latency", 32'(total), 32'(LATENCY));
    score("ign");
    @(negedge clk);
    check("ign_no_second", 32'(bus.oDone), 32'd0);
    repeat (12) @(negedge clk);
    check("ign_state_idle", 32'(dbg_state), 32'(ST_IDLE));

    // reset mid-run aborts; a start in the reset cycle is overridden
    start_op(8'd7, 8'd9, 8'h33);
    repeat (3) @(negedge clk);
    rst              = 1'b1;
    bus.iStart       = 1'b1;
    bus.iOperandA    = 8'd7;
    bus.iOperandB    = 8'd9;
    bus.iDestination = 8'h33;
    @(negedge clk);
    rst        = 1'b0;
    bus.iStart = 1'b0;
    check("rmid_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rmid_busy", 32'(bus.oBusy), 32'd0);
    saw_done = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (bus.oDone === 1'b1) saw_done = 1'b1;
    end
    check("rmid_no_done", 32'(saw_done), 32'd0);
    check("rmid_result", 32'(bus.oResult), 32'h0000);
    check("rmid_waddr", 32'(bus.oWriteAddr), 32'h00);
    run_op("after_rst", 8'd2, 8'd3, 8'h44, 16'h0006);

    // back-to-back: new start accepted in the DONE cycle
    exp_q.push_back({8'h01, 16'h002A});
    start_op(8'd6, 8'd7, 8'h01);
    wait_done(lat, busy_ok);
    check("b2b1_latency", 32'(lat), 32'(LATENCY));
    check("b2b1_busy_run", 32'(busy_ok), 32'd1);
    check("b2b1_busy_done", 32'(bus.oBusy), 32'd0);
    score("b2b1");
    exp_q.push_back({8'h02, 16'h0010});
    bus.iStart       = 1'b1;
    bus.iOperandA    = 8'd4;
    bus.iOperandB    = 8'd4;
    bus.iDestination = 8'h02;
    @(negedge clk);
    bus.iStart = 1'b0;
    check("b2b2_busy_start", 32'(bus.oBusy), 32'd1);
    check("b2b2_done_low", 32'(bus.oDone), 32'd0);
    check("b2b2_result_held", 32'(bus.oResult), 32'h002A);
    wait_done(lat, busy_ok);
    check("b2b2_latency", 32'(lat), 32'(LATENCY));
    check("b2b2_busy_run", 32'(busy_ok), 32'd1);
    score("b2b2");
    @(negedge clk);
    check("b2b2_done_pulse", 32'(bus.oDone), 32'd0);

    // randomized products against the arithmetic model
    for (int i = 0; i < 20; i++) begin
      ra = WIDTH'($urandom_range(0, 255));
      rb = WIDTH'($urandom_range(0, 255));
      rd = ADDR_W'($urandom_range(0, 255));
      run_op($sformatf("rnd%0d", i), ra, rb, rd, model_mul(ra, rb));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
